// File: rtl/atomic_request_unit.sv
// atomic_request_unit: sequences instruction fetch and data access for the
// multicycle MIPS datapath, generates the PC/register-file enable, tracks the
// LL/SC reservation (invalidated by coherence snoops) and halts the core if a
// data access hangs longer than the watchdog allows.
module atomic_request_unit #(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int WD_W    = 8
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              ihit,
   input  logic              dhit,
   input  logic              cu_dREN,
   input  logic              cu_dWEN,
   input  logic              cu_datomic,
   input  logic              cu_halt,
   input  logic [WORD_W-1:0] cu_addr,
   input  logic              snoop_valid,
   input  logic [WORD_W-1:0] snoop_addr,
   output logic              iREN,
   output logic              dREN,
   output logic              dWEN,
   output logic              datomic,
   output logic              pc_en,
   output logic [WORD_W-1:0] sc_result,
   output logic              link_valid,
   output logic              cpu_halt,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DATA  = 2'd1,
      HALT  = 2'd2
   } state_t;

   localparam int WD_LIMIT_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_LIMIT_INT[WD_W-1:0];

   state_t              state;
   logic [WORD_W-3:0]   link_addr;
   logic [WD_W-1:0]     wd_cnt;

   logic mem_op;
   logic is_ll;
   logic is_sc;
   logic addr_match;
   logic snoop_hit;
   logic sc_local_fail;
   logic unused_addr_bits;

   // Reservations are tracked per word, so the byte offset never matters.
   assign unused_addr_bits = ^{cu_addr[1:0], snoop_addr[1:0]};

   assign mem_op        = cu_dREN | cu_dWEN;
   assign is_ll         = cu_dREN & cu_datomic;
   assign is_sc         = cu_dWEN & cu_datomic;
   assign addr_match    = (link_addr == cu_addr[WORD_W-1:2]);
   assign snoop_hit     = snoop_valid & link_valid &
                          (link_addr == snoop_addr[WORD_W-1:2]);
   assign sc_local_fail = is_sc & (~link_valid | ~addr_match | snoop_hit);

   // State, reservation, watchdog and sticky status flags. A snoop hit clears
   // the reservation by default; later assignments (an LL completing) win.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= FETCH;
         link_valid  <= 1'b0;
         link_addr   <= '0;
         wd_cnt      <= '0;
         cpu_halt    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (snoop_hit) begin
            link_valid <= 1'b0;
         end
         case (state)
            FETCH: begin
               if (ihit) begin
                  if (cu_halt) begin
                     state    <= HALT;
                     cpu_halt <= 1'b1;
                  end else if (mem_op && !sc_local_fail) begin
                     state  <= DATA;
                     wd_cnt <= '0;
                  end
               end
            end
            DATA: begin
               if (dhit) begin
                  state <= FETCH;
                  if (is_ll) begin
                     link_valid <= 1'b1;
                     link_addr  <= cu_addr[WORD_W-1:2];
                  end else if (is_sc) begin
                     link_valid <= 1'b0;
                  end else if (cu_dWEN && addr_match) begin
                     link_valid <= 1'b0;
                  end
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
                  if ((TIMEOUT != 0) && (wd_cnt == WD_LIMIT)) begin
                     state       <= HALT;
                     timeout_err <= 1'b1;
                     cpu_halt    <= 1'b1;
                  end
               end
            end
            HALT: begin
               cpu_halt <= 1'b1;
            end
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // Request and retire outputs decoded from the state and the current hits;
   // while reset is asserted only the fetch request is presented.
   always_comb begin
      iREN      = 1'b0;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      datomic   = 1'b0;
      pc_en     = 1'b0;
      sc_result = '0;
      if (!nRST) begin
         iREN = 1'b1;
      end else begin
         case (state)
            FETCH: begin
               iREN = 1'b1;
               if (ihit && !cu_halt && (!mem_op || sc_local_fail)) begin
                  pc_en = 1'b1;
               end
            end
            DATA: begin
               dREN    = cu_dREN;
               dWEN    = cu_dWEN;
               datomic = cu_datomic;
               if (dhit) begin
                  pc_en = 1'b1;
                  if (is_sc) begin
                     sc_result = {{(WORD_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               iREN = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atomic_request_unit.sv
// tb_atomic_request_unit: directed sequence through reset, ALU ops, loads,
// LL/SC success and failure paths, halt and the stall watchdog.
module tb_atomic_request_unit;

   logic        clk;
   logic        n_rst;
   logic        ihit;
   logic        dhit;
   logic        cu_dren;
   logic        cu_dwen;
   logic        cu_datomic;
   logic        cu_halt;
   logic [31:0] cu_addr;
   logic        snoop_valid;
   logic [31:0] snoop_addr;
   logic        iren;
   logic        dren;
   logic        dwen;
   logic        datomic;
   logic        pc_en;
   logic [31:0] sc_result;
   logic        link_valid;
   logic        cpu_halt;
   logic        timeout_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic [39:0] val;
   } exp_t;

   exp_t exp_q[$];

   atomic_request_unit #(.WORD_W(32), .TIMEOUT(4), .WD_W(8)) dut (
      .CLK         (clk),
      .nRST        (n_rst),
      .ihit        (ihit),
      .dhit        (dhit),
      .cu_dREN     (cu_dren),
      .cu_dWEN     (cu_dwen),
      .cu_datomic  (cu_datomic),
      .cu_halt     (cu_halt),
      .cu_addr     (cu_addr),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .iREN        (iren),
      .dREN        (dren),
      .dWEN        (dwen),
      .datomic     (datomic),
      .pc_en       (pc_en),
      .sc_result   (sc_result),
      .link_valid  (link_valid),
      .cpu_halt    (cpu_halt),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_stimulus(input logic i_hit, input logic d_hit,
                                 input logic d_ren, input logic d_wen,
                                 input logic atom, input logic halt,
                                 input logic [31:0] addr, input logic s_valid,
                                 input logic [31:0] s_addr);
      ihit        = i_hit;
      dhit        = d_hit;
      cu_dren     = d_ren;
      cu_dwen     = d_wen;
      cu_datomic  = atom;
      cu_halt     = halt;
      cu_addr     = addr;
      snoop_valid = s_valid;
      snoop_addr  = s_addr;
   endtask

   task automatic check_output();
      exp_t        e;
      logic [39:0] obs;
      obs = {iren, dren, dwen, datomic, pc_en, link_valid, cpu_halt,
             timeout_err, sc_result};
      if (exp_q.size() == 0) begin
         failures++;
         $error("[TB] FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         checks++;
         assert (obs === e.val) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h (iREN,dREN,dWEN,datomic,pc_en,link_valid,cpu_halt,timeout_err,sc_result)",
                   e.tag, obs, e.val);
         end
      end
   endtask

   // One cycle: record what the DUT must show, sample mid-cycle, then move
   // just past the next rising edge so the following step can drive inputs.
   task automatic step(input string tag, input logic [7:0] flags,
                       input logic [31:0] sc);
      exp_t e;
      e.tag = tag;
      e.val = {flags, sc};
      exp_q.push_back(e);
      @(negedge clk);
      check_output();
      @(posedge clk);
      #1;
   endtask

   // Flag order: iREN dREN dWEN datomic pc_en link_valid cpu_halt timeout_err
   initial begin
      n_rst = 1'b0;
      apply_stimulus(1, 0, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      step("reset_hold", 8'b1000_0000, 0);

      n_rst = 1'b1;
      step("post_reset_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      step("post_reset_data", 8'b0100_0000, 0);
      apply_stimulus(0, 1, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      step("post_reset_dhit", 8'b0100_1000, 0);

      apply_stimulus(1, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         step($sformatf("alu_%0d", i), 8'b1000_1000, 0);
      end

      apply_stimulus(1, 1, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      step("lw_fetch_dhit_ignored", 8'b1000_0000, 0);
      apply_stimulus(0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      step("lw_wait1", 8'b0100_0000, 0);
      step("lw_wait2", 8'b0100_0000, 0);
      apply_stimulus(0, 1, 1, 0, 0, 0, 32'h100, 0, 32'h0);
      step("lw_dhit", 8'b0100_1000, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("lw_back_fetch", 8'b1000_0000, 0);

      apply_stimulus(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 1, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll_dhit", 8'b0101_1000, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("ll_linked", 8'b1000_0100, 0);
      apply_stimulus(1, 0, 0, 1, 1, 0, 32'h200, 0, 32'h0);
      step("sc_ok_fetch", 8'b1000_0100, 0);
      apply_stimulus(0, 1, 0, 1, 1, 0, 32'h200, 0, 32'h0);
      step("sc_ok_dhit", 8'b0011_1100, 1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("sc_ok_unlinked", 8'b1000_0000, 0);

      apply_stimulus(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll2_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 1, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll2_dhit", 8'b0101_1000, 0);
      apply_stimulus(1, 0, 0, 1, 1, 0, 32'h200, 1, 32'h200);
      step("sc_snoop_fail", 8'b1000_1100, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("sc_snoop_after", 8'b1000_0000, 0);

      apply_stimulus(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll3_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 1, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll3_dhit", 8'b0101_1000, 0);
      apply_stimulus(1, 0, 0, 1, 1, 0, 32'h204, 0, 32'h0);
      step("sc_addr_fail", 8'b1000_1100, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("sc_addr_after", 8'b1000_0100, 0);

      apply_stimulus(1, 0, 0, 1, 0, 0, 32'h200, 0, 32'h0);
      step("sw_fetch", 8'b1000_0100, 0);
      apply_stimulus(0, 1, 0, 1, 0, 0, 32'h200, 0, 32'h0);
      step("sw_dhit", 8'b0010_1100, 0);
      apply_stimulus(1, 0, 0, 1, 1, 0, 32'h200, 0, 32'h0);
      step("sc_after_sw_fail", 8'b1000_1000, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("sc_after_sw_idle", 8'b1000_0000, 0);

      apply_stimulus(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll4_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 1, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll4_dhit", 8'b0101_1000, 0);
      apply_stimulus(1, 0, 1, 0, 1, 0, 32'h200, 0, 32'h0);
      step("ll5_fetch", 8'b1000_0100, 0);
      apply_stimulus(0, 1, 1, 0, 1, 0, 32'h200, 1, 32'h200);
      step("ll5_dhit_snoop", 8'b0101_1100, 0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("ll_wins_snoop", 8'b1000_0100, 0);

      apply_stimulus(1, 0, 0, 0, 0, 1, 32'h0, 0, 32'h0);
      step("halt_fetch", 8'b1000_0100, 0);
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(i[0], 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
         step($sformatf("halt_sticky_%0d", i), 8'b0000_0110, 0);
      end
      n_rst = 1'b0;
      step("halt_in_reset", 8'b1000_0110, 0);
      n_rst = 1'b1;
      apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
      step("halt_cleared", 8'b1000_0000, 0);

      apply_stimulus(1, 0, 1, 0, 0, 0, 32'h300, 0, 32'h0);
      step("wd_fetch", 8'b1000_0000, 0);
      apply_stimulus(0, 0, 1, 0, 0, 0, 32'h300, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step($sformatf("wd_wait_%0d", i), 8'b0100_0000, 0);
      end
      step("wd_halt", 8'b0000_0011, 0);
      apply_stimulus(1, 1, 1, 0, 0, 0, 32'h300, 0, 32'h0);
      step("wd_halt_sticky", 8'b0000_0011, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
